// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: raster-ordered 3-bit RGB test-pattern source on a valid/ready pixel stream.
// Optional macro VGA_PATGEN_FRAME_CNT_EN adds frame_count and a one-pixel-per-frame scrolling checkerboard.
//
// state  | meaning
// IDLE   | nothing presented; waiting for enable with a nonzero resolution
// ACTIVE | a pixel of the current frame is presented, held until accepted
module vga_pattern_gen #(
    parameter int CHECKER_LOG2 = 3,
    parameter int COORD_W      = 16
) (
    input  logic        pxl_clk,
    input  logic        pxl_rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [2:0]  solid_color,
    input  logic [31:0] hoz_res,
    input  logic [31:0] vert_res,
    output logic [2:0]  pxl_data,
    output logic        pxl_valid,
    input  logic        pxl_ready,
    output logic        pxl_sof,
    output logic        pxl_eol
`ifdef VGA_PATGEN_FRAME_CNT_EN
    ,
    output logic [15:0] frame_count
`endif
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0] bar_w_q, bar_w_d, bar_cnt_q, bar_cnt_d;
    logic [2:0]         bar_idx_q, bar_idx_d;
    logic [1:0]         pat_q, pat_d;
    logic [2:0]         solid_q, solid_d;
    logic [2:0]         data_q, data_d;
    logic               valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;
    logic [COORD_W-1:0] res_h, res_v, bar_w_new, fc_term;
    logic               start, xfer, last_x, last_y, frame_end, restart, load, chk_bit;
    logic               unused_res_hi;

    assign res_h         = hoz_res[COORD_W-1:0];
    assign res_v         = vert_res[COORD_W-1:0];
    assign unused_res_hi = ^{hoz_res[31:COORD_W], vert_res[31:COORD_W]};
    assign bar_w_new     = ((res_h >> 3) == '0) ? ONE : (res_h >> 3);
    assign start         = enable && (res_h != '0) && (res_v != '0);
    assign xfer          = valid_q && pxl_ready;
    assign last_x        = (x_q == h_q - ONE);
    assign last_y        = (y_q == v_q - ONE);
    assign frame_end     = xfer && last_x && last_y;
    assign restart       = start && ((state_q == IDLE) || frame_end);

`ifdef VGA_PATGEN_FRAME_CNT_EN
    logic [15:0] fc_q, fc_d;
    assign fc_d        = frame_end ? fc_q + 16'd1 : fc_q;
    assign fc_term     = COORD_W'(fc_d);
    assign frame_count = fc_q;

    always_ff @(posedge pxl_clk or posedge pxl_rst) begin
        if (pxl_rst) fc_q <= '0;
        else         fc_q <= fc_d;
    end
`else
    assign fc_term = '0;
`endif

    always_ff @(posedge pxl_clk or posedge pxl_rst) begin
        if (pxl_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACTIVE;
            ACTIVE:  if (frame_end && !start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Everything presented is computed from the *next* coordinates and config so outputs stay registered.
    always_comb begin
        h_d       = h_q;
        v_d       = v_q;
        pat_d     = pat_q;
        solid_d   = solid_q;
        bar_w_d   = bar_w_q;
        x_d       = x_q;
        y_d       = y_q;
        bar_idx_d = bar_idx_q;
        bar_cnt_d = bar_cnt_q;
        valid_d   = valid_q;
        data_d    = data_q;
        sof_d     = sof_q;
        eol_d     = eol_q;
        load      = 1'b0;
        chk_bit   = 1'b0;
        if (restart) begin
            h_d       = res_h;
            v_d       = res_v;
            pat_d     = pattern_sel;
            solid_d   = solid_color;
            bar_w_d   = bar_w_new;
            x_d       = '0;
            y_d       = '0;
            bar_idx_d = '0;
            bar_cnt_d = bar_w_new - ONE;
            load      = 1'b1;
        end else if (state_q == ACTIVE && frame_end) begin
            valid_d = 1'b0;
            data_d  = '0;
            sof_d   = 1'b0;
            eol_d   = 1'b0;
        end else if (state_q == ACTIVE && xfer) begin
            load = 1'b1;
            if (last_x) begin
                x_d       = '0;
                y_d       = y_q + ONE;
                bar_idx_d = '0;
                bar_cnt_d = bar_w_q - ONE;
            end else begin
                x_d = x_q + ONE;
                if (bar_cnt_q == '0) begin
                    bar_cnt_d = bar_w_q - ONE;
                    if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_cnt_d = bar_cnt_q - ONE;
                end
            end
        end
        if (load) begin
            valid_d = 1'b1;
            sof_d   = (x_d == '0) && (y_d == '0);
            eol_d   = (x_d == h_d - ONE);
            chk_bit = ((((x_d + fc_term) >> CHECKER_LOG2) ^ (y_d >> CHECKER_LOG2)) & ONE) != '0;
            case (pat_d)
                2'd0:    data_d = 3'd7 - bar_idx_d;
                2'd1:    data_d = chk_bit ? 3'b111 : 3'b000;
                2'd2:    data_d = solid_d;
                default: data_d = ((x_d == '0) || (x_d == h_d - ONE) || (y_d == '0) || (y_d == v_d - ONE))
                                  ? 3'b111 : 3'b000;
            endcase
        end
    end

    always_ff @(posedge pxl_clk or posedge pxl_rst) begin
        if (pxl_rst) begin
            h_q       <= '0;
            v_q       <= '0;
            pat_q     <= '0;
            solid_q   <= '0;
            bar_w_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            bar_idx_q <= '0;
            bar_cnt_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            pat_q     <= pat_d;
            solid_q   <= solid_d;
            bar_w_q   <= bar_w_d;
            x_q       <= x_d;
            y_q       <= y_d;
            bar_idx_q <= bar_idx_d;
            bar_cnt_q <= bar_cnt_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            sof_q     <= sof_d;
            eol_q     <= eol_d;
        end
    end

    assign pxl_data  = data_q;
    assign pxl_valid = valid_q;
    assign pxl_sof   = sof_q;
    assign pxl_eol   = eol_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Testbench for vga_pattern_gen: pixel-position vector table, directed corner sequences and
// randomized config/backpressure checked against a coordinate-level reference model.
module tb_vga_pattern_gen;
    logic        pxl_clk = 1'b0;
    logic        pxl_rst, enable, pxl_ready;
    logic [1:0]  pattern_sel;
    logic [2:0]  solid_color;
    logic [31:0] hoz_res, vert_res;
    logic [2:0]  pxl_data;
    logic        pxl_valid, pxl_sof, pxl_eol;

    int checks = 0;
    int errors = 0;

    vga_pattern_gen dut (
        .pxl_clk    (pxl_clk),
        .pxl_rst    (pxl_rst),
        .enable     (enable),
        .pattern_sel(pattern_sel),
        .solid_color(solid_color),
        .hoz_res    (hoz_res),
        .vert_res   (vert_res),
        .pxl_data   (pxl_data),
        .pxl_valid  (pxl_valid),
        .pxl_ready  (pxl_ready),
        .pxl_sof    (pxl_sof),
        .pxl_eol    (pxl_eol)
    );

    always #5 pxl_clk = ~pxl_clk;

    // Reference model: which pixel of which frame should be on the bus after each edge.
    bit m_valid;
    int m_x, m_y, m_h, m_v, m_pat, m_solid;
    int n_xfer, n_sof_xfer, n_gap, frame_xfers, exp_frame_len;

    typedef struct packed {
        int pat; int h; int v; int solid; int x; int y; int data; int eol;
    } vec_t;
    vec_t vecs[$];

    function automatic int exp_pix(int x, int y, int pat, int solid, int h, int v);
        int bw, idx;
        case (pat)
            0: begin
                bw = h / 8;
                if (bw == 0) bw = 1;
                idx = x / bw;
                if (idx > 7) idx = 7;
                return 7 - idx;
            end
            1: return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 7 : 0;
            2: return solid;
            default: return (x == 0 || x == h - 1 || y == 0 || y == v - 1) ? 7 : 0;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int h, v;
        bit go, new_frame;
        h = int'(hoz_res[15:0]);
        v = int'(vert_res[15:0]);
        go = enable && h != 0 && v != 0;
        new_frame = 1'b0;
        if (!m_valid) new_frame = go;
        else if (pxl_ready) begin
            if (m_x == m_h - 1 && m_y == m_v - 1) begin
                if (go) new_frame = 1'b1;
                else    m_valid = 1'b0;
            end else if (m_x == m_h - 1) begin
                m_x = 0;
                m_y++;
            end else begin
                m_x++;
            end
        end
        if (new_frame) begin
            m_valid = 1'b1;
            m_x = 0; m_y = 0; m_h = h; m_v = v;
            m_pat = int'(pattern_sel);
            m_solid = int'(solid_color);
        end
    endtask

    task automatic step();
        if (pxl_valid && pxl_ready) begin
            n_xfer++;
            if (pxl_sof) begin
                if (exp_frame_len > 0 && frame_xfers > 0) chk("frame_len", frame_xfers, exp_frame_len);
                frame_xfers = 0;
                n_sof_xfer++;
            end
            frame_xfers++;
        end
        model_edge();
        @(posedge pxl_clk);
        #1;
        if (!pxl_valid) n_gap++;
        chk("valid", int'(pxl_valid), int'(m_valid));
        if (m_valid) begin
            chk("data", int'(pxl_data), exp_pix(m_x, m_y, m_pat, m_solid, m_h, m_v));
            chk("sof", int'(pxl_sof), (m_x == 0 && m_y == 0) ? 1 : 0);
            chk("eol", int'(pxl_eol), (m_x == m_h - 1) ? 1 : 0);
        end
    endtask

    task automatic do_reset();
        pxl_rst = 1'b1;
        m_valid = 1'b0;
        frame_xfers = 0;
        @(posedge pxl_clk);
        #1;
        pxl_rst = 1'b0;
    endtask

    task automatic set_cfg(input int pat, input int h, input int v, input int solid);
        pattern_sel = 2'(pat);
        hoz_res     = 32'(h);
        vert_res    = 32'(v);
        solid_color = 3'(solid);
    endtask

    initial begin
        pxl_rst = 1'b1; enable = 1'b0; pxl_ready = 1'b0;
        set_cfg(0, 0, 0, 0);
        m_valid = 1'b0; exp_frame_len = 0; frame_xfers = 0;
        n_xfer = 0; n_sof_xfer = 0; n_gap = 0;

        //            pat  h   v  sol  x   y  data eol
        vecs.push_back('{0, 16,  4, 0,  0,  0, 7, 0});
        vecs.push_back('{0, 16,  4, 0,  1,  0, 7, 0});
        vecs.push_back('{0, 16,  4, 0,  2,  0, 6, 0});
        vecs.push_back('{0, 16,  4, 0, 15,  1, 0, 1});
        vecs.push_back('{0, 16,  4, 0, 13,  3, 1, 0});
        vecs.push_back('{0, 10,  2, 0,  0,  0, 7, 0});
        vecs.push_back('{0, 10,  2, 0,  6,  0, 1, 0});
        vecs.push_back('{0, 10,  2, 0,  8,  1, 0, 0});
        vecs.push_back('{0, 10,  2, 0,  9,  0, 0, 1});
        vecs.push_back('{0, 20,  1, 0, 13,  0, 1, 0});
        vecs.push_back('{0, 20,  1, 0, 18,  0, 0, 0});
        vecs.push_back('{1, 32, 16, 0,  8,  0, 7, 0});
        vecs.push_back('{1, 32, 16, 0,  0,  0, 0, 0});
        vecs.push_back('{1, 32, 16, 0,  8,  8, 0, 0});
        vecs.push_back('{1, 32, 16, 0,  0,  8, 7, 0});
        vecs.push_back('{1, 32, 16, 0, 31, 15, 0, 1});
        vecs.push_back('{2,  4,  2, 5,  2,  1, 5, 0});
        vecs.push_back('{3,  8,  3, 0,  0,  1, 7, 0});
        vecs.push_back('{3,  8,  3, 0,  3,  1, 0, 0});
        vecs.push_back('{3,  8,  3, 0,  7,  1, 7, 1});
        vecs.push_back('{3,  8,  3, 0,  3,  2, 7, 0});
        vecs.push_back('{3,  1,  1, 0,  0,  0, 7, 1});
        vecs.push_back('{0,  1,  3, 0,  0,  2, 7, 1});

        #1;
        chk("rst_valid", int'(pxl_valid), 0);
        chk("rst_data", int'(pxl_data), 0);
        chk("rst_sof", int'(pxl_sof), 0);
        chk("rst_eol", int'(pxl_eol), 0);
        @(posedge pxl_clk);
        #1;
        pxl_rst = 1'b0;

        foreach (vecs[i]) begin
            do_reset();
            set_cfg(vecs[i].pat, vecs[i].h, vecs[i].v, vecs[i].solid);
            enable = 1'b1;
            pxl_ready = 1'b1;
            repeat (1 + vecs[i].x + vecs[i].y * vecs[i].h) step();
            chk("vec_data", int'(pxl_data), vecs[i].data);
            chk("vec_eol", int'(pxl_eol), vecs[i].eol);
            chk("vec_sof", int'(pxl_sof), (vecs[i].x == 0 && vecs[i].y == 0) ? 1 : 0);
        end

        // Back-to-back frames with no bubble.
        do_reset();
        set_cfg(0, 16, 4, 0);
        enable = 1'b1; pxl_ready = 1'b1;
        step();
        n_xfer = 0; n_sof_xfer = 0; n_gap = 0; frame_xfers = 0; exp_frame_len = 64;
        repeat (128) step();
        chk("a_xfers", n_xfer, 128);
        chk("a_sofs", n_sof_xfer, 2);
        chk("a_gaps", n_gap, 0);

        // Random backpressure on a bordered frame.
        do_reset();
        set_cfg(3, 8, 3, 0);
        n_sof_xfer = 0; exp_frame_len = 24;
        for (int i = 0; i < 400; i++) begin
            pxl_ready = 1'($urandom_range(0, 1));
            step();
        end
        chk("b_frames_seen", (n_sof_xfer >= 3) ? 1 : 0, 1);
        exp_frame_len = 0;

        // Enable dropped and pattern changed mid-frame.
        do_reset();
        set_cfg(2, 8, 2, 3);
        enable = 1'b1; pxl_ready = 1'b1;
        repeat (12) step();
        chk("c_solid", int'(pxl_data), 3);
        enable = 1'b0;
        pattern_sel = 2'd0;
        repeat (5) step();
        chk("c_idle", int'(pxl_valid), 0);
        repeat (3) step();
        enable = 1'b1;
        step();
        chk("c_bars", int'(pxl_data), 7);
        chk("c_sof", int'(pxl_sof), 1);

        // Asynchronous reset mid-frame, then zero resolution.
        do_reset();
        set_cfg(0, 8, 4, 0);
        enable = 1'b1; pxl_ready = 1'b1;
        repeat (22) step();
        chk("d_pre_valid", int'(pxl_valid), 1);
        #2;
        pxl_rst = 1'b1;
        m_valid = 1'b0;
        #1;
        chk("d_rst_valid", int'(pxl_valid), 0);
        chk("d_rst_data", int'(pxl_data), 0);
        chk("d_rst_sof", int'(pxl_sof), 0);
        chk("d_rst_eol", int'(pxl_eol), 0);
        @(posedge pxl_clk);
        #1;
        pxl_rst = 1'b0;
        step();
        chk("d_restart_valid", int'(pxl_valid), 1);
        chk("d_restart_sof", int'(pxl_sof), 1);
        do_reset();
        set_cfg(0, 0, 4, 0);
        repeat (10) step();
        chk("h0_valid", int'(pxl_valid), 0);

        // Randomized configuration, enable and backpressure.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                pattern_sel = 2'($urandom_range(0, 3));
                solid_color = 3'($urandom_range(0, 7));
                hoz_res     = {16'($urandom_range(0, 3)), 16'($urandom_range(0, 12))};
                vert_res    = {16'($urandom_range(0, 3)), 16'($urandom_range(0, 4))};
            end
            enable    = ($urandom_range(0, 9) != 0);
            pxl_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Upstream pixel source for the VGA output core. Generates a raster-ordered 3-bit RGB test-pattern stream (colour bars, checkerboard, solid, border) for a programmable active resolution. Pixels are delivered over a valid/ready stream with start-of-frame and end-of-line markers, so the VGA core pulls one pixel per active pixel clock.

Parameters:
CHECKER_LOG2, 3, log2 of checkerboard square size in pixels (default 8x8).
COORD_W, 16, width of internal x/y counters; hoz_res/vert_res bits above COORD_W are ignored.

Ports:
pxl_clk  input  1  pixel clock.
pxl_rst  input  1  reset, asynchronous, active-high.
enable  input  1  start/continue frame generation.
pattern_sel  input  2  0 colour bars, 1 checkerboard, 2 solid, 3 border.
solid_color  input  3  {r,g,b} for pattern 2.
hoz_res  input  32  active pixels per line.
vert_res  input  32  active lines per frame.
pxl_data  output  3  {r,g,b} pixel.
pxl_valid  output  1  pxl_data/markers valid.
pxl_ready  input  1  downstream accepts pixel.
pxl_sof  output  1  high with pixel (0,0).
pxl_eol  output  1  high with last pixel of each line.

Behaviour:
- Async reset: state IDLE; pxl_valid=0, pxl_data=0, pxl_sof=0, pxl_eol=0; x=y=0; latched config cleared. Reset mid-frame abandons the frame; next frame restarts at (0,0) with sof.
- Config (pattern_sel, solid_color, hoz_res, vert_res truncated to COORD_W) latched only at frame start; changes mid-frame have no effect until next frame.
- Transfer occurs when pxl_valid && pxl_ready. While pxl_valid && !pxl_ready, pxl_data/sof/eol held stable. pxl_valid never drops without a transfer (except reset).
- All outputs registered.
- States:
  - IDLE: pxl_valid=0. If enable=1 and latched-to-be H!=0 and V!=0: latch config, present pixel (0,0) with sof=1 on the next cycle (1-cycle latency from enable), go ACTIVE. If H=0 or V=0: remain IDLE.
  - ACTIVE: on transfer, advance x; at x=H-1 wrap x to 0 and increment y. eol=1 when x=H-1. sof=1 only at (0,0).
  - On transfer of last pixel (H-1,V-1): if enable=1 and resolution nonzero, latch new config and present (0,0) next cycle with no bubble; else pxl_valid=0 next cycle, go IDLE.
- enable is sampled only in IDLE and at frame end; deassertion mid-frame completes the current frame.
- H=1: every pixel has eol=1. H=1,V=1: every pixel has sof=1 and eol=1.
- Pattern 0: bar_width=max(H>>3,1); bar index counter steps every bar_width pixels, saturates at 7 (last bar absorbs remainder), resets each line; pxl_data=7-bar_idx.
- Pattern 1: pxl_data=((x>>CHECKER_LOG2)^(y>>CHECKER_LOG2))[0] ? 3'b111 : 3'b000.
- Pattern 2: pxl_data=latched solid_color.
- Pattern 3: 3'b111 if x==0, x==H-1, y==0 or y==V-1; else 3'b000.

Optional Feature:
Macro VGA_PATGEN_FRAME_CNT_EN. Defined: adds output port frame_count [15:0], reset 0, increments by 1 (wrapping 0xFFFF->0) on the cycle after each last-pixel transfer; pattern 1 becomes animated: checker x term uses (x+frame_count) so the board scrolls one pixel per frame. Undefined: port absent, checkerboard static.

Test Plan:
- H=16,V=4, pattern 0, ready=1, enable held: 64 transfers; per line data 7,7,6,6,...,0,0; eol at x=15; sof on first pixel only; second frame begins with no gap cycle.
- H=10,V=2, pattern 0: bar_width=1; line data 7,6,5,4,3,2,1,0,0,0.
- H=32,V=16, pattern 1, CHECKER_LOG2=3: pixel (8,0)=7, (0,0)=0, (8,8)=0, (0,8)=7.
- Random ready backpressure, H=8,V=3, pattern 3: pxl_data/sof/eol stable while stalled; border pixels 7, interior 0; exactly 24 transfers per frame.
- Drop enable at pixel (3,1) of H=8,V=2 frame; change pattern_sel from 2 to 0 mid-frame: frame completes with solid colour, valid=0 cycle after last transfer, state IDLE; re-enable -> new frame uses colour bars.
- Assert pxl_rst at (5,2) of a frame: outputs 0 immediately (asynchronously); after release with enable=1, first pixel (0,0) with sof=1 one cycle later; H=0 with enable=1 -> pxl_valid stays 0.
